uart_tx: RTL and testbench

Serial UART transmitter for the UART module. Accepts one parallel byte per valid/ready handshake and shifts it out on `tx` as an asynchronous frame: start bit, LSB-first data, optional parity, stop bit(s). Bit timing comes from an internal one-shot bit timer with a power-of-two period, the same period scheme the receive-side timer uses. It is the transmit counterpart of the receive path and sits between the CPU-side data interface and the TX pin.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_bit_timer.sv | 37 +++
 rtl/uart_tx.sv | 139 +++++++++++++
 tb/tb_uart_tx.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmit and receive paths.
package uart_pkg;

    // Frame-level FSM states common to the TX and RX controllers.
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;

    // Serial line levels: the line rests high and a frame opens with a low bit.
    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;

    // Number of clk cycles in one bit period for a power-of-two divisor.
    function automatic int bit_cycles(input int divisor_bits);
        return 1 << divisor_bits;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// One-shot bit-period timer: counts 0..BIT_CYCLES-1 and flags the last cycle.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int DIVISOR_BITS = 7
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic done
);

    localparam logic [DIVISOR_BITS-1:0] LAST = DIVISOR_BITS'(bit_cycles(DIVISOR_BITS) - 1);

    logic [DIVISOR_BITS-1:0] cnt_q;
    logic [DIVISOR_BITS-1:0] cnt_d;

    // Reload on start (held there while the owner keeps start high), else count up.
    always_comb begin
        cnt_d = cnt_q + DIVISOR_BITS'(1);
        if (start) begin
            cnt_d = '0;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one byte per valid/ready handshake, framed as start,
// LSB-first data, optional parity and 1 or 2 stop bits on a registered tx line.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DIVISOR_BITS = 7,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy
);

    localparam int              IDX_W     = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic            STOP_LAST = (STOP_BITS == 2);

    uart_state_t          state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 stop_q, stop_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 timer_start;
    logic                 bit_done;

    // Bit timer: held at zero while idle and restarted at every bit boundary.
    uart_bit_timer #(
        .DIVISOR_BITS(DIVISOR_BITS)
    ) u_bit_timer (
        .clk  (clk),
        .rst  (rst),
        .start(timer_start),
        .done (bit_done)
    );

    assign tx_ready = (state_q == IDLE) & ~rst;

    // Next-state, datapath and line level; tx_d follows the current state so the
    // line lags the state by one cycle and every bit still lasts a full period.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        par_d       = par_q;
        idx_d       = idx_q;
        stop_d      = stop_q;
        timer_start = bit_done;
        tx_d        = LINE_IDLE;

        case (state_q)
            IDLE: begin
                timer_start = 1'b1;
                idx_d       = '0;
                stop_d      = 1'b0;
                tx_d        = LINE_IDLE;
                if (tx_valid && tx_ready) begin
                    shift_d = tx_data;
                    par_d   = (PARITY_EN != 0) ? ((^tx_data) ^ (PARITY_ODD != 0)) : 1'b0;
                    state_d = START;
                end
            end
            START: begin
                tx_d = LINE_START;
                if (bit_done) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                tx_d = shift_q[0];
                if (bit_done) begin
                    shift_d = shift_q >> 1;
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            PARITY: begin
                tx_d = par_q;
                if (bit_done) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                tx_d = LINE_IDLE;
                if (bit_done) begin
                    if (stop_q == STOP_LAST) begin
                        stop_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        stop_d = stop_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // Control registers; reset abandons any frame in flight and idles the line.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            stop_q  <= 1'b0;
            tx_q    <= LINE_IDLE;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            stop_q  <= stop_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

    // Data registers need no reset: they are only observed after a handshake loads them.
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
        par_q   <= par_d;
    end

    assign tx   = tx_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: five configurations run in parallel, each with
// a stimulus process, a handshake hook that queues the expected frame, and a
// line monitor that decodes tx like a receiver and compares against the queue.
module tb_uart_tx;

    localparam int DIVB = 2;
    localparam int BC   = 1 << DIVB;
    localparam int NCFG = 5;

    localparam int         DB_A  [NCFG] = '{8, 8, 8, 8, 5};
    localparam int         PE_A  [NCFG] = '{0, 1, 1, 0, 0};
    localparam int         PO_A  [NCFG] = '{0, 0, 1, 0, 0};
    localparam int         SB_A  [NCFG] = '{1, 1, 1, 2, 1};
    localparam logic [7:0] DIR_A [NCFG] = '{8'h55, 8'hA3, 8'hA3, 8'h01, 8'h1F};

    typedef struct {
        int          e;
        logic [11:0] bits;
    } exp_t;

    logic clk = 1'b0;
    int   cyc = 0;
    int   errs = 0;
    int   checks = 0;
    int   done_cnt = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    for (genvar g = 0; g < NCFG; g++) begin : gcfg
        localparam int DB = DB_A[g];
        localparam int PE = PE_A[g];
        localparam int PO = PO_A[g];
        localparam int SB = SB_A[g];
        localparam int NB = 1 + DB + PE + SB;
        localparam int N  = BC * NB;

        logic          rst      = 1'b1;
        logic          tx_valid = 1'b0;
        logic [DB-1:0] tx_data  = '0;
        logic          tx_ready;
        logic          tx;
        logic          busy;

        exp_t q[$];
        int   hs_cnt = 0;
        int   hs_e   = 0;

        uart_tx #(
            .DIVISOR_BITS(DIVB),
            .DATA_BITS   (DB),
            .PARITY_EN   (PE),
            .PARITY_ODD  (PO),
            .STOP_BITS   (SB)
        ) dut (
            .clk     (clk),
            .rst     (rst),
            .tx_valid(tx_valid),
            .tx_data (tx_data),
            .tx_ready(tx_ready),
            .tx      (tx),
            .busy    (busy)
        );

        function automatic string nm(input string s);
            return $sformatf("cfg%0d_%s", g, s);
        endfunction

        // Reference frame: bit k of the result is the k-th bit put on the line.
        function automatic logic [11:0] frame_of(input logic [DB-1:0] d);
            logic [11:0] f;
            int          ones;
            f    = '1;
            f[0] = 1'b0;
            ones = 0;
            for (int i = 0; i < DB; i++) begin
                f[1+i] = d[i];
                if (d[i]) ones++;
            end
            if (PE != 0) f[1+DB] = ((ones % 2) == 1) ^ (PO != 0);
            return f;
        endfunction

        // Handshake hook: queue the expected frame and record the cycle after the edge.
        always @(posedge clk) begin
            if (!rst && tx_valid && tx_ready) begin
                q.push_back('{e: cyc + 1, bits: frame_of(tx_data)});
                hs_e = cyc + 1;
                hs_cnt++;
            end
        end

        // Line monitor: on each falling start edge, pop and check the whole frame.
        initial begin : mon
            exp_t        x;
            logic [11:0] act;
            bit          hold_ok, bsy_ok, aborted;
            int          t0;
            forever begin
                @(negedge clk);
                if (rst || tx !== 1'b0) continue;
                t0 = cyc;
                if (q.size() == 0) begin
                    checks++;
                    errs++;
                    $display("FAIL %s: start bit at cycle %0d, expected no frame", nm("unexpected_start"), t0);
                    continue;
                end
                x = q.pop_front();
                chk(nm("start_time"), t0, x.e + 1);
                act     = '1;
                hold_ok = 1'b1;
                bsy_ok  = 1'b1;
                aborted = 1'b0;
                for (int k = 0; k < N; k++) begin
                    if (k > 0) @(negedge clk);
                    if (rst) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (k % BC == BC / 2) act[k/BC] = tx;
                    if (tx !== x.bits[k/BC]) hold_ok = 1'b0;
                    if (busy !== (k < N - 1)) bsy_ok = 1'b0;
                end
                if (!aborted) begin
                    chk(nm("frame_bits"), act, x.bits);
                    chk(nm("bit_hold"), hold_ok, 1);
                    chk(nm("busy_window"), bsy_ok, 1);
                end
            end
        end

        task automatic idle(input int n);
            repeat (n) begin
                @(posedge clk);
                #1;
            end
        endtask

        task automatic send(input logic [7:0] d, input bit hold);
            int h0, n;
            h0       = hs_cnt;
            n        = 0;
            tx_data  = d[DB-1:0];
            tx_valid = 1'b1;
            while (hs_cnt == h0 && n < 4 * N) begin
                @(posedge clk);
                #1;
                n++;
            end
            if (hs_cnt == h0) begin
                checks++;
                errs++;
                $display("FAIL %s: no handshake within %0d cycles, expected one", nm("handshake_timeout"), n);
            end
            if (!hold) tx_valid = 1'b0;
        endtask

        initial begin : stim
            int         bad, n, e1;
            logic [7:0] r;

            idle(3);
            chk(nm("rst_tx"), tx, 1);
            chk(nm("rst_busy"), busy, 0);
            chk(nm("rst_ready"), tx_ready, 0);
            rst = 1'b0;
            #1;
            bad = 0;
            for (int i = 0; i < 100; i++) begin
                if (tx !== 1'b1 || busy !== 1'b0 || tx_ready !== 1'b1) bad++;
                idle(1);
            end
            chk(nm("idle_hold_bad_cycles"), bad, 0);

            // Directed byte; ready must be back in time for a handshake N+1 edges later.
            send(DIR_A[g], 1'b0);
            chk(nm("busy_after_hs"), busy, 1);
            n = 0;
            while (tx_ready !== 1'b1 && n < 4 * N) begin
                idle(1);
                n++;
            end
            chk(nm("ready_latency"), n + 1, N + 1);

            // Back-to-back with valid held; data toggles while frames are in flight.
            idle($urandom_range(0, 3));
            send(8'h01, 1'b1);
            e1 = hs_e;
            for (int i = 0; i < N - 4; i++) begin
                tx_data = DB'($urandom);
                idle(1);
            end
            send(8'hFF, 1'b0);
            chk(nm("b2b_handshake_spacing"), hs_e - e1, N + 1);
            for (int i = 0; i < N / 2; i++) begin
                tx_data = DB'($urandom);
                idle(1);
            end
            idle(N);

            // One-cycle reset during data bit 3 on the line, then a clean frame.
            send(8'h0F, 1'b0);
            idle(4 * BC + 1);
            rst = 1'b1;
            idle(1);
            rst = 1'b0;
            #1;
            chk(nm("abort_tx"), tx, 1);
            chk(nm("abort_busy"), busy, 0);
            chk(nm("abort_ready"), tx_ready, 1);
            send(8'h80, 1'b0);

            // Random bytes with random idle gaps.
            for (int i = 0; i < 6; i++) begin
                idle($urandom_range(0, 3));
                r = 8'($urandom);
                send(r, 1'b0);
            end
            idle(N + 4);
            chk(nm("queue_drained"), q.size(), 0);
            done_cnt++;
        end
    end

    initial begin : top_ctl
        int n;
        n = 0;
        while (done_cnt < NCFG && n < 20000) begin
            @(posedge clk);
            n++;
        end
        if (done_cnt < NCFG) begin
            checks++;
            errs++;
            $display("FAIL run_timeout: %0d configs finished, expected %0d", done_cnt, NCFG);
        end
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
